// File: rtl/vsd_pkg.sv
`default_nettype none
// ============================================================================
// Module : vsd_pkg
// Brief  : Shared types and constants for the vsd_router SD/SPI router.
// Rev    : 1.0  initial release
// ============================================================================
package vsd_pkg;

    typedef enum logic [0:0] {
        REAL = 1'b0,
        VIRT = 1'b1
    } route_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } own_state_t;

    localparam int         NCH_MAX    = 8;
    localparam logic [3:0] OWNER_NONE = 4'hF;

endpackage
`default_nettype wire

// File: rtl/vsd_router_if.sv
`default_nettype none
// ============================================================================
// Module : vsd_router_if
// Brief  : Controller / virtual-card / physical-card SPI bundle for vsd_router.
// Rev    : 1.0  initial release
// ============================================================================
interface vsd_router_if #(
    parameter int NCH = 3
);
    logic [NCH-1:0] img_mounted;
    logic           img_size_nz;
    logic [3:0]     real_sel;
    logic [NCH-1:0] ctl_cs;
    logic [NCH-1:0] ctl_sclk;
    logic [NCH-1:0] ctl_mosi;
    logic [NCH-1:0] ctl_miso;
    logic [NCH-1:0] vsd_ss;
    logic [NCH-1:0] vsd_miso;
    logic           sd_cs;
    logic           sd_sck;
    logic           sd_mosi;
    logic           sd_miso;
    logic [NCH-1:0] have;
    logic [NCH-1:0] led_act;

    modport slave (
        input  img_mounted, img_size_nz, real_sel, ctl_cs, ctl_sclk, ctl_mosi,
               vsd_miso, sd_miso,
        output ctl_miso, vsd_ss, sd_cs, sd_sck, sd_mosi, have, led_act
    );

    modport master (
        output img_mounted, img_size_nz, real_sel, ctl_cs, ctl_sclk, ctl_mosi,
               vsd_miso, sd_miso,
        input  ctl_miso, vsd_ss, sd_cs, sd_sck, sd_mosi, have, led_act
    );
endinterface
`default_nettype wire

// File: rtl/vsd_led_stretch.sv
`default_nettype none
// ============================================================================
// Module : vsd_led_stretch
// Brief  : Per-channel activity LED; stretched by a counter when
//          VSD_LED_STRETCH_EN is defined, else a 1-cycle delayed ~cs.
// Rev    : 1.0  initial release
// ============================================================================
module vsd_led_stretch #(
    parameter int CNT_W = 20
) (
    input  wire  clk_sys,
    input  wire  reset_n,
    input  wire  cs,
    input  wire  sclk,
    output logic led
);

`ifdef VSD_LED_STRETCH_EN
    logic             r_sclk_q;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_q <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sclk_q <= sclk;
            if (sclk && !r_sclk_q && !cs)
                r_cnt <= '1;
            else if (r_cnt != '0)
                r_cnt <= r_cnt - 1'b1;
        end
    end

    assign led = (r_cnt != '0);
`else
    // Counter width only matters when stretching is compiled in.
    localparam int c_unused_cnt_w = CNT_W;

    logic r_led;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            r_led <= 1'b0;
        else
            r_led <= ~cs;
    end

    assign led = r_led;
`endif

endmodule
`default_nettype wire

// File: rtl/vsd_router.sv
`default_nettype none
// ============================================================================
// Module : vsd_router
// Brief  : N-channel SD/SPI router: per-channel virtual card or the single
//          physical SD slot, with idle-deferred route changes and exclusive
//          physical-card ownership. Optional macro: VSD_LED_STRETCH_EN.
// Rev    : 1.0  initial release
// ============================================================================
module vsd_router
    import vsd_pkg::*;
#(
    parameter int NCH       = 3,
    parameter int LED_CNT_W = 20
) (
    input wire          clk_sys,
    input wire          reset_n,
    vsd_router_if.slave bus
);

    route_t         r_route [NCH];
    logic [NCH-1:0] r_mounted;
    logic [NCH-1:0] r_have;
    own_state_t     r_state;
    logic [3:0]     r_owner;

    logic [NCH-1:0] w_virt;
    logic [NCH-1:0] w_sel;
    logic [NCH-1:0] w_sel_real;
    logic [NCH-1:0] w_owned_by;
    logic [NCH-1:0] w_vsd_ss;
    logic [NCH-1:0] w_ctl_miso;
    logic [NCH-1:0] w_led;
    logic           w_release;
    logic           w_sd_cs;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign w_virt[i]     = (r_route[i] == VIRT);
        assign w_sel[i]      = (bus.real_sel == 4'(i));
        assign w_sel_real[i] = w_sel[i] && !w_virt[i];
        assign w_owned_by[i] = (r_state == OWNED) && (r_owner == 4'(i));
        assign w_vsd_ss[i]   = bus.ctl_cs[i] | ~w_virt[i];
        assign w_ctl_miso[i] = w_virt[i]     ? bus.vsd_miso[i] :
                               w_owned_by[i] ? bus.sd_miso     : 1'b1;

        // Route only switches while this controller's bus is deselected.
        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n)
                r_route[i] <= REAL;
            else if (bus.ctl_cs[i])
                r_route[i] <= r_mounted[i] ? VIRT : REAL;
        end

        vsd_led_stretch #(
            .CNT_W (LED_CNT_W)
        ) u_led (
            .clk_sys (clk_sys),
            .reset_n (reset_n),
            .cs      (bus.ctl_cs[i]),
            .sclk    (bus.ctl_sclk[i]),
            .led     (w_led[i])
        );
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_mounted <= '0;
            r_have    <= '0;
        end else begin
            r_mounted <= (r_mounted & ~bus.img_mounted)
                       | ({NCH{bus.img_size_nz}} & bus.img_mounted);
            r_have    <= w_virt | w_sel;
        end
    end

    // Owner may only let go once its own chip select is high.
    assign w_release = |(w_owned_by & bus.ctl_cs & ~w_sel_real);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_owner <= OWNER_NONE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_sel_real) begin
                        r_state <= OWNED;
                        r_owner <= bus.real_sel;
                    end
                end
                OWNED: begin
                    if (w_release) begin
                        r_state <= IDLE;
                        r_owner <= OWNER_NONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_owner <= OWNER_NONE;
                end
            endcase
        end
    end

    assign w_sd_cs      = ~|(w_owned_by & ~bus.ctl_cs);
    assign bus.sd_cs    = w_sd_cs;
    assign bus.sd_sck   = |(w_owned_by & bus.ctl_sclk) & ~w_sd_cs;
    assign bus.sd_mosi  = |(w_owned_by & bus.ctl_mosi) & ~w_sd_cs;
    assign bus.vsd_ss   = w_vsd_ss;
    assign bus.ctl_miso = w_ctl_miso;
    assign bus.have     = r_have;
    assign bus.led_act  = w_led;

endmodule
`default_nettype wire

// File: tb/tb_vsd_router.sv
`default_nettype none
// ============================================================================
// Module : tb_vsd_router
// Brief  : Directed + randomized self-checking bench for vsd_router against a
//          behavioural channel/ownership model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_vsd_router;

    localparam int NCH     = 3;
    localparam int LED_W   = 4;
    localparam int LED_MAX = (1 << LED_W) - 1;
    localparam int N_RAND  = 3000;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk_sys = ~clk_sys;

    vsd_router_if #(.NCH(NCH)) bus ();

    vsd_router #(
        .NCH       (NCH),
        .LED_CNT_W (LED_W)
    ) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: disk state per channel plus who holds the card.
    bit m_mounted [NCH];
    bit m_virt    [NCH];
    bit m_have    [NCH];
    bit m_led     [NCH];
    bit m_sclk_q  [NCH];
    int m_cnt     [NCH];
    int m_owner;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_mounted[i] = 0; m_virt[i] = 0; m_have[i] = 0;
            m_led[i] = 0; m_sclk_q[i] = 0; m_cnt[i] = 0;
        end
        m_owner = -1;
    endfunction

    function automatic void model_step();
        int rs;
        int n_owner;
        bit n_virt [NCH];
        rs      = int'(bus.real_sel);
        n_owner = m_owner;
        if (m_owner < 0) begin
            if (rs < NCH && !m_virt[rs]) n_owner = rs;
        end else if (bus.ctl_cs[m_owner] && (rs != m_owner || m_virt[m_owner])) begin
            n_owner = -1;
        end
        for (int i = 0; i < NCH; i++) begin
            n_virt[i] = bus.ctl_cs[i] ? m_mounted[i] : m_virt[i];
            m_have[i] = m_virt[i] || (rs == i);
            if (bus.img_mounted[i]) m_mounted[i] = bus.img_size_nz;
`ifdef VSD_LED_STRETCH_EN
            if (bus.ctl_sclk[i] && !m_sclk_q[i] && !bus.ctl_cs[i]) m_cnt[i] = LED_MAX;
            else if (m_cnt[i] > 0) m_cnt[i]--;
            m_sclk_q[i] = bus.ctl_sclk[i];
            m_led[i]    = (m_cnt[i] != 0);
`else
            m_led[i]    = !bus.ctl_cs[i];
`endif
        end
        for (int i = 0; i < NCH; i++) m_virt[i] = n_virt[i];
        m_owner = n_owner;
    endfunction

    task automatic compare_all();
        logic [NCH-1:0] e_ss, e_miso, e_have, e_led;
        logic e_cs, e_sck, e_mosi;
        e_cs   = (m_owner < 0) ? 1'b1 : bus.ctl_cs[m_owner];
        e_sck  = (m_owner >= 0 && !e_cs) ? bus.ctl_sclk[m_owner] : 1'b0;
        e_mosi = (m_owner >= 0 && !e_cs) ? bus.ctl_mosi[m_owner] : 1'b0;
        for (int i = 0; i < NCH; i++) begin
            e_ss[i]   = bus.ctl_cs[i] | !m_virt[i];
            e_miso[i] = m_virt[i] ? bus.vsd_miso[i] : ((m_owner == i) ? bus.sd_miso : 1'b1);
            e_have[i] = m_have[i];
            e_led[i]  = m_led[i];
        end
        check_eq("sd_cs",    32'(bus.sd_cs),    32'(e_cs));
        check_eq("sd_sck",   32'(bus.sd_sck),   32'(e_sck));
        check_eq("sd_mosi",  32'(bus.sd_mosi),  32'(e_mosi));
        check_eq("vsd_ss",   32'(bus.vsd_ss),   32'(e_ss));
        check_eq("ctl_miso", 32'(bus.ctl_miso), 32'(e_miso));
        check_eq("have",     32'(bus.have),     32'(e_have));
        check_eq("led_act",  32'(bus.led_act),  32'(e_led));
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_sd_cs"},    32'(bus.sd_cs),    32'd1);
        check_eq({tag, "_sd_sck"},   32'(bus.sd_sck),   32'd0);
        check_eq({tag, "_sd_mosi"},  32'(bus.sd_mosi),  32'd0);
        check_eq({tag, "_vsd_ss"},   32'(bus.vsd_ss),   32'h7);
        check_eq({tag, "_ctl_miso"}, 32'(bus.ctl_miso), 32'h7);
        check_eq({tag, "_have"},     32'(bus.have),     32'h0);
        check_eq({tag, "_led"},      32'(bus.led_act),  32'h0);
    endtask

    task automatic edge_step();
        @(posedge clk_sys);
        model_step();
        #1;
    endtask

    task automatic sample();
        @(negedge clk_sys);
        compare_all();
    endtask

    task automatic rand_inputs();
        int v;
        for (int i = 0; i < NCH; i++) begin
            if ($urandom_range(7) == 0) bus.ctl_cs[i] = ~bus.ctl_cs[i];
            bus.ctl_sclk[i] = bus.ctl_cs[i] ? 1'b0 : 1'($urandom_range(1));
            bus.ctl_mosi[i] = 1'($urandom_range(1));
        end
        bus.img_mounted = '0;
        if ($urandom_range(24) == 0) bus.img_mounted[$urandom_range(NCH - 1)] = 1'b1;
        bus.img_size_nz = 1'($urandom_range(3) != 0);
        if ($urandom_range(30) == 0) begin
            v = int'($urandom_range(4));
            bus.real_sel = (v == 4) ? 4'hF : 4'(v);
        end
        bus.vsd_miso = NCH'($urandom);
        bus.sd_miso  = 1'($urandom_range(1));
    endtask

    initial begin
        // Reset with a busy-looking bus: outputs must still show reset values.
        bus.img_mounted = '0;
        bus.img_size_nz = 1'b0;
        bus.real_sel    = 4'd2;
        bus.ctl_cs      = '0;
        bus.ctl_sclk    = '1;
        bus.ctl_mosi    = '1;
        bus.vsd_miso    = '0;
        bus.sd_miso     = 1'b0;
        model_reset();
        #12;
        check_reset_vals("rst");
        bus.ctl_cs   = '1;
        bus.ctl_sclk = '0;
        bus.ctl_mosi = '0;
        @(negedge clk_sys);
        reset_n = 1'b1;

        // Physical card claimed by ch2 after the first edge.
        edge_step();
        sample();
        check_eq("t1_have", 32'(bus.have), 32'h4);
        bus.ctl_cs[2] = 1'b0;
        #1 check_eq("t1_sdcs_low", 32'(bus.sd_cs), 32'd0);
        bus.ctl_cs[2] = 1'b1;
        #1 check_eq("t1_sdcs_high", 32'(bus.sd_cs), 32'd1);

        // Mount ch0 mid-transfer: route must wait for cs to rise.
        bus.ctl_cs[0]      = 1'b0;
        bus.img_mounted[0] = 1'b1;
        bus.img_size_nz    = 1'b1;
        edge_step();
        bus.img_mounted = '0;
        sample();
        check_eq("t2_ss_held", 32'(bus.vsd_ss[0]), 32'd1);
        edge_step();
        sample();
        check_eq("t2_ss_held2", 32'(bus.vsd_ss[0]), 32'd1);
        bus.ctl_cs[0] = 1'b1;
        edge_step();
        bus.ctl_cs[0] = 1'b0;
        bus.vsd_miso  = '0;
        #1 check_eq("t2_ss_virt", 32'(bus.vsd_ss[0]), 32'd0);
        bus.vsd_miso[0] = 1'b1;
        #1 check_eq("t2_miso1", 32'(bus.ctl_miso[0]), 32'd1);
        bus.vsd_miso[0] = 1'b0;
        #1 check_eq("t2_miso0", 32'(bus.ctl_miso[0]), 32'd0);
        sample();

        // No physical owner selected.
        bus.ctl_cs   = '1;
        bus.real_sel = 4'hF;
        edge_step();
        edge_step();
        bus.ctl_cs[2:1]   = 2'b00;
        bus.ctl_sclk      = '1;
        bus.ctl_mosi      = '1;
        bus.sd_miso       = 1'b0;
        #1;
        check_eq("t5_sd_cs",   32'(bus.sd_cs),         32'd1);
        check_eq("t5_sd_sck",  32'(bus.sd_sck),        32'd0);
        check_eq("t5_sd_mosi", 32'(bus.sd_mosi),       32'd0);
        check_eq("t5_miso",    32'(bus.ctl_miso[2:1]), 32'h3);
        check_eq("t5_have",    32'(bus.have),          32'h1);
        sample();
        bus.ctl_cs   = '1;
        bus.ctl_sclk = '0;

        for (int n = 0; n < N_RAND; n++) begin
            edge_step();
            rand_inputs();
            sample();
            if (n == N_RAND / 2) begin
                #1 reset_n = 1'b0;
                #1;
                model_reset();
                check_reset_vals("arst");
                @(negedge clk_sys);
                reset_n = 1'b1;
                compare_all();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
